alu_drv: RTL

Command-side initiator for the 4-bit `alu` datapath. It accepts operation commands over a valid/ready port and buffers them in a small FIFO. It issues one command at a time on the ALU's `OPCODE`/`OP1`/`OP2` inputs, waits a fixed result latency, and captures the ALU result. The result is returned on a valid/ready response port. It sits between the test/host sequencer and `alu`, and is the driving end of the ALU operand interface.

---
 rtl/alu_drv.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_drv.sv
// Command-side initiator for the 4-bit alu: buffers commands in a FIFO, issues
// them one at a time, waits LAT cycles and returns the result. Optional checks: ALU_DRV_ASSERT_EN.
module alu_drv #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_opcode,
  input  logic [W-1:0]           cmd_op1,
  input  logic [W-1:0]           cmd_op2,
  output logic [2:0]             OPCODE,
  output logic [W-1:0]           OP1,
  output logic [W-1:0]           OP2,
  input  logic [W-1:0]           alu_res,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2:0]             rsp_opcode,
  output logic [W-1:0]           rsp_res,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam int EW = 3 + 2 * W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [LW-1:0] wait_cnt;
  logic          push;
  logic          pop;

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && (count != '0);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // Storage needs no reset: a flush only has to clear the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_opcode, cmd_op1, cmd_op2};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Operands are only ever loaded on a pop, so they stay put through ISSUE/WAIT/RESP.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      OPCODE     <= '0;
      OP1        <= '0;
      OP2        <= '0;
      rsp_opcode <= '0;
      rsp_res    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {OPCODE, OP1, OP2} <= mem[rd_ptr];
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= LW'(LAT);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == LW'(1)) begin
            rsp_res    <= alu_res;
            rsp_opcode <= OPCODE;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - LW'(1);
          end
        end
        default: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_DRV_ASSERT_EN
  logic          past_rstn;
  logic [1:0]    prev_state;
  logic [EW-1:0] prev_ops;
  logic          prev_stall;
  logic [2:0]    prev_rsp_opcode;
  logic [W-1:0]  prev_rsp_res;

  always_ff @(posedge clk) begin
    past_rstn       <= rstn;
    prev_state      <= state;
    prev_ops        <= {OPCODE, OP1, OP2};
    prev_stall      <= rsp_valid && !rsp_ready;
    prev_rsp_opcode <= rsp_opcode;
    prev_rsp_res    <= rsp_res;
  end

  // Values seen here belong to the cycle that is ending, compared with the one before it.
  always @(posedge clk) begin
    if (past_rstn) begin
      assert (count <= CW'(DEPTH));
      assert (!(push && count == CW'(DEPTH)));
      if (state != ST_IDLE && prev_state != ST_IDLE)
        assert ({OPCODE, OP1, OP2} == prev_ops);
      if (prev_stall)
        assert (rsp_valid && rsp_opcode == prev_rsp_opcode && rsp_res == prev_rsp_res);
      if (rsp_valid)
        assert (state == ST_RESP);
      cover (count == CW'(DEPTH));
      cover (rsp_valid && rsp_ready);
    end
  end
`endif

endmodule
